// File: rtl/sqrt_seq_core_if.sv
// Valid/ready handshake bundle for the sequential square-root engine.
// The master drives the radicand and out_ready; the slave returns root/remainder.
interface sqrt_seq_core_if #(
    parameter int DATA_W = 16
) ();
    localparam int ROOT_W = DATA_W / 2;
    localparam int REM_W  = ROOT_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] radicand;
    logic              out_valid;
    logic              out_ready;
    logic [ROOT_W-1:0] root;
    logic [REM_W-1:0]  rem;

    modport master (
        output in_valid, radicand, out_ready,
        input  in_ready, out_valid, root, rem
    );

    modport slave (
        input  in_valid, radicand, out_ready,
        output in_ready, out_valid, root, rem
    );
endinterface

// File: rtl/sqrt_seq_core.sv
// Restoring digit-by-digit integer square root, one root bit per clock.
// Result is registered on completion and held until the consumer takes it.
module sqrt_seq_core #(
    parameter int DATA_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    sqrt_seq_core_if.slave   bus
);
    localparam int ROOT_W = DATA_W / 2;
    localparam int REM_W  = ROOT_W + 1;
    localparam int CALC_W = 17;
    localparam int CNT_W  = $clog2(ROOT_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] rad_r;
    logic [CALC_W-1:0] rem_r;
    logic [ROOT_W-1:0] root_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [ROOT_W-1:0] root_out_r;
    logic [REM_W-1:0]  rem_out_r;

    logic [CALC_W-1:0] rem_sh_s;
    logic [CALC_W-1:0] trial_s;
    logic [CALC_W-1:0] rem_nxt_s;
    logic [ROOT_W-1:0] root_nxt_s;
    logic              last_s;

    // One restoring step: bring down two radicand bits and try subtracting (root<<2)|1.
    always_comb begin
        rem_sh_s   = (rem_r << 2'd2) | CALC_W'(rad_r[DATA_W-1 -: 2]);
        trial_s    = (CALC_W'(root_r) << 2'd2) | CALC_W'(1'b1);
        rem_nxt_s  = rem_sh_s;
        root_nxt_s = root_r << 1'b1;
        if (rem_sh_s >= trial_s) begin
            rem_nxt_s  = rem_sh_s - trial_s;
            root_nxt_s = (root_r << 1'b1) | ROOT_W'(1'b1);
        end else begin
            rem_nxt_s  = rem_sh_s;
            root_nxt_s = root_r << 1'b1;
        end
    end

    assign last_s = (cnt_r == CNT_W'(ROOT_W - 1));

    // Control FSM, iteration datapath and registered handshake/result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rad_r       <= {DATA_W{1'b0}};
            rem_r       <= {CALC_W{1'b0}};
            root_r      <= {ROOT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            root_out_r  <= {ROOT_W{1'b0}};
            rem_out_r   <= {REM_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        rad_r      <= bus.radicand;
                        rem_r      <= {CALC_W{1'b0}};
                        root_r     <= {ROOT_W{1'b0}};
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= ST_CALC;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_CALC: begin
                    rad_r  <= rad_r << 2'd2;
                    rem_r  <= rem_nxt_s;
                    root_r <= root_nxt_s;
                    cnt_r  <= cnt_r + CNT_W'(1'b1);
                    // Result registers only move on the final iteration.
                    if (last_s) begin
                        root_out_r  <= root_nxt_s;
                        rem_out_r   <= rem_nxt_s[REM_W-1:0];
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r     <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.root      = root_out_r;
    assign bus.rem       = rem_out_r;
endmodule

// File: tb/tb_sqrt_seq_core.sv
// Directed bench for sqrt_seq_core: handshake, latency, hold, abort and square boundaries.
module tb_sqrt_seq_core;
    logic clk_i;
    logic rst_ni;
    int   n_chk;
    int   n_bad;

    sqrt_seq_core_if #(.DATA_W(16)) bus ();

    sqrt_seq_core #(.DATA_W(16)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_isqrt(input logic [31:0] x);
        logic [31:0] r;
        r = 32'd0;
        while ((r + 32'd1) * (r + 32'd1) <= x) r = r + 32'd1;
        return r;
    endfunction

    task automatic do_op(input logic [15:0] x, input logic [7:0] er, input logic [8:0] erem,
                         input int hold, input bit inj);
        int cyc;
        @(negedge clk_i);
        chk("ready_before", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.radicand = x;
        @(negedge clk_i);
        bus.in_valid = inj;
        bus.radicand = inj ? 16'd49 : 16'hA5A5;
        chk("busy", 32'(bus.in_ready), 32'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 32'(cyc), 32'd8);
        chk("root", 32'(bus.root), 32'(er));
        chk("rem", 32'(bus.rem), 32'(erem));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_root", 32'(bus.root), 32'(er));
            chk("hold_rem", 32'(bus.rem), 32'(erem));
        end
        bus.out_ready = 1'b1;
        @(negedge clk_i);
        bus.out_ready = 1'b0;
        chk("taken_valid", 32'(bus.out_valid), 32'd0);
        chk("taken_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] r;
        n_chk = 0;
        n_bad = 0;
        rst_ni = 1'b0;
        bus.in_valid = 1'b0;
        bus.radicand = 16'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_root", 32'(bus.root), 32'd0);
        chk("rst_rem", 32'(bus.rem), 32'd0);
        rst_ni = 1'b1;

        do_op(16'd0, 8'd0, 9'd0, 0, 1'b0);
        do_op(16'hFFFF, 8'd255, 9'd510, 0, 1'b0);
        do_op(16'd144, 8'd12, 9'd0, 0, 1'b0);
        do_op(16'd200, 8'd14, 9'd4, 5, 1'b0);
        do_op(16'd200, 8'd14, 9'd4, 0, 1'b1);
        do_op(16'd49, 8'd7, 9'd0, 0, 1'b0);

        // abort during CALC
        @(negedge clk_i);
        bus.in_valid = 1'b1;
        bus.radicand = 16'd200;
        @(negedge clk_i);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_root", 32'(bus.root), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_op(16'd81, 8'd9, 9'd0, 0, 1'b0);

        // abort while a result is pending in DONE
        @(negedge clk_i);
        bus.in_valid = 1'b1;
        bus.radicand = 16'd225;
        @(negedge clk_i);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk_i);
        chk("done_valid", 32'(bus.out_valid), 32'd1);
        chk("done_root", 32'(bus.root), 32'd15);
        #1 rst_ni = 1'b0;
        #1;
        chk("done_abort_valid", 32'(bus.out_valid), 32'd0);
        chk("done_abort_root", 32'(bus.root), 32'd0);
        chk("done_abort_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // perfect squares and one-below-square boundaries
        for (int n = 0; n < 256; n++) begin
            v = 32'(n * n);
            do_op(v[15:0], 8'(n), 9'd0, 0, 1'b0);
        end
        for (int n = 1; n <= 256; n++) begin
            v = 32'(n * n - 1);
            do_op(v[15:0], 8'(n - 1), 9'(2 * n - 2), 0, 1'b0);
        end
        for (int k = 0; k < 100; k++) begin
            v = 32'($urandom_range(0, 65535));
            r = ref_isqrt(v);
            do_op(v[15:0], r[7:0], 9'(v - r * r), 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
